// File: rtl/fifo_sync_param.sv
// Single-clock synchronous FIFO with configurable width and depth, programmable
// almost-full/almost-empty thresholds, error pulses, synchronous flush and optional FWFT read.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync_param: DEPTH must be a power of two and at least 4");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("fifo_sync_param: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("fifo_sync_param: FWFT must be 0 or 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status flags come only from the registered count, never from the requests.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Accept rules: a read needs a non-empty FIFO; a write needs room, where a
    // same-edge accepted read frees a slot. Empty + write + read never bypasses.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && !wr_ok;
            underflow <= rd_en && !rd_ok;
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (rst && !clear && wr_ok) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_out <= '0;
                end else if (clear) begin
                    data_out <= '0;
                end else if (rd_ok) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-read instance checked against a queue model,
// and an FWFT instance exercised with hand-written sequences.
module tb_fifo_sync_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk;
    logic          rst;
    logic          clear, wr_en, rd_en;
    logic [DW-1:0] data_in, data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    logic          f_clear, f_wr_en, f_rd_en;
    logic [DW-1:0] f_data_in, f_data_out;
    logic          f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [CW-1:0] f_count;

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .clear(f_clear), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard and model state
    logic [DW-1:0] exp_q[$];
    int            m_count;
    logic [DW-1:0] m_dout;
    logic          m_ovf, m_unf;
    int            n_checks;
    int            n_fail;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            exp_count;
        logic          exp_ovf;
        logic          exp_unf;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_std();
        check("count", 32'(count), 32'(m_count));
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("almost_full", 32'(almost_full), 32'(m_count >= AF));
        check("almost_empty", 32'(almost_empty), 32'(m_count <= AE));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
        check("data_out", 32'(data_out), 32'(m_dout));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_dout  = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock of the standard instance: drive, advance the model, compare.
    task automatic do_cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
        logic w_ok, r_ok;
        r_ok = r && (m_count != 0);
        w_ok = w && ((m_count != DEPTH) || r_ok);
        wr_en = w; rd_en = r; data_in = d; clear = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            m_ovf = w && !w_ok;
            m_unf = r && !r_ok;
            if (r_ok) m_dout = exp_q.pop_front();
            if (w_ok) exp_q.push_back(d);
            m_count = exp_q.size();
        end
        check_std();
    endtask

    task automatic f_cycle(input logic w, input logic r, input logic [DW-1:0] d);
        f_wr_en = w; f_rd_en = r; f_data_in = d;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        f_clear = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_data_in = '0;
        model_reset();

        vecs[0] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 0, exp_ovf: 1'b0, exp_unf: 1'b1, exp_dout: 8'h00};
        vecs[1] = '{wr: 1'b1, rd: 1'b1, din: 8'h11, exp_count: 1, exp_ovf: 1'b0, exp_unf: 1'b1, exp_dout: 8'h00};
        vecs[2] = '{wr: 1'b1, rd: 1'b0, din: 8'h22, exp_count: 2, exp_ovf: 1'b0, exp_unf: 1'b0, exp_dout: 8'h00};
        vecs[3] = '{wr: 1'b1, rd: 1'b1, din: 8'h33, exp_count: 2, exp_ovf: 1'b0, exp_unf: 1'b0, exp_dout: 8'h11};
        vecs[4] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 1, exp_ovf: 1'b0, exp_unf: 1'b0, exp_dout: 8'h22};
        vecs[5] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 0, exp_ovf: 1'b0, exp_unf: 1'b0, exp_dout: 8'h33};
        vecs[6] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_count: 0, exp_ovf: 1'b0, exp_unf: 1'b1, exp_dout: 8'h33};
        vecs[7] = '{wr: 1'b0, rd: 1'b0, din: 8'h00, exp_count: 0, exp_ovf: 1'b0, exp_unf: 1'b0, exp_dout: 8'h33};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_std();
        check("f_reset_empty", 32'(f_empty), 32'd1);
        check("f_reset_dout", 32'(f_data_out), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_cycle(vecs[i].wr, vecs[i].rd, vecs[i].din, 1'b0);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_unf", i), 32'(underflow), 32'(vecs[i].exp_unf));
            check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
        end

        // Fill and drain
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, 1'b0, DW'(i), 1'b0);
            if (i == 12) check("af_clear_at_13", 32'(almost_full), 32'd0);
            if (i == 13) check("af_set_at_14", 32'(almost_full), 32'd1);
            if (i == 14) check("not_full_at_15", 32'(full), 32'd0);
        end
        check("full_after_16", 32'(full), 32'd1);
        do_cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("count_held_16", 32'(count), 32'd16);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("ovf_one_cycle", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
            check("drain_order", 32'(data_out), 32'(i));
        end
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("unf_pulse", 32'(underflow), 32'd1);
        check("dout_hold_0f", 32'(data_out), 32'h0F);

        // Simultaneous write and read at full
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
        do_cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        check("full_rw_count", 32'(count), 32'd16);
        check("full_rw_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("aa_last_out", 32'(data_out), 32'hAA);

        // Asynchronous reset mid-stream with count = 5
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_cycle(1'b1, 1'b0, 8'h77, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Wrap-around: interleaved pairs with random occupancy
        for (int i = 0; i < 40; i++) begin
            do_cycle(1'b1, 1'(($urandom_range(0, 3) == 0)), DW'($urandom_range(0, 255)), 1'b0);
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), DW'($urandom_range(0, 255)), 1'b0);
        end
        for (int i = 0; i < DEPTH + 1 && m_count > 0; i++) do_cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Clear with a simultaneous write at count = 9
        for (int i = 0; i < 9; i++) do_cycle(1'b1, 1'b0, DW'(8'h90 + i), 1'b0);
        check("pre_clear_count", 32'(count), 32'd9);
        do_cycle(1'b1, 1'b0, 8'h99, 1'b1);
        check("clear_count", 32'(count), 32'd0);
        check("clear_empty", 32'(empty), 32'd1);
        do_cycle(1'b1, 1'b0, 8'h5A, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check("post_clear_data", 32'(data_out), 32'h5A);
        check("post_clear_empty", 32'(empty), 32'd1);

        // FWFT instance
        f_cycle(1'b1, 1'b0, 8'h55);
        check("fwft_fall_through", 32'(f_data_out), 32'h55);
        check("fwft_not_empty", 32'(f_empty), 32'd0);
        f_cycle(1'b0, 1'b0, 8'h00);
        check("fwft_hold", 32'(f_data_out), 32'h55);
        f_cycle(1'b0, 1'b1, 8'h00);
        check("fwft_pop_empty", 32'(f_empty), 32'd1);
        check("fwft_pop_zero", 32'(f_data_out), 32'h00);
        f_cycle(1'b1, 1'b0, 8'h01);
        check("fwft_first", 32'(f_data_out), 32'h01);
        f_cycle(1'b1, 1'b0, 8'h02);
        check("fwft_head_kept", 32'(f_data_out), 32'h01);
        check("fwft_count2", 32'(f_count), 32'd2);
        f_cycle(1'b0, 1'b1, 8'h00);
        check("fwft_next", 32'(f_data_out), 32'h02);
        check("fwft_count1", 32'(f_count), 32'd1);
        f_cycle(1'b0, 1'b1, 8'h00);
        check("fwft_drained", 32'(f_data_out), 32'h00);
        f_cycle(1'b0, 1'b1, 8'h00);
        check("fwft_unf", 32'(f_underflow), 32'd1);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
